gmii_rx_frame_ctrl: RTL and testbench

Receive-side frame controller that sits directly behind the RGMII-to-GMII DDR capture stage, in the gmii_rx_clk domain. It delineates Ethernet frames on the 8-bit GMII stream by locking on preamble/SFD, then strips both. It forwards payload bytes (DA through FCS) with start and end markers. Per frame it produces length and error status and keeps saturating good/bad frame counters for the upper MAC/UDP layers.

---
 rtl/eth_rx_pkg.sv | 34 +++
 rtl/gmii_rx_da_match.sv | 34 +++
 rtl/gmii_rx_frame_ctrl.sv | 164 ++++++++++++++++
 tb/tb_gmii_rx_frame_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the GMII receive frame path.
package eth_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    DROP = 2'd3
  } state_t;

  localparam logic [2:0] ERR_OK   = 3'd0;
  localparam logic [2:0] ERR_RX   = 3'd1;
  localparam logic [2:0] ERR_RUNT = 3'd2;
  localparam logic [2:0] ERR_OVER = 3'd3;
  localparam logic [2:0] ERR_DA   = 3'd4;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;

  // Byte idx of a MAC address in wire order (idx 0 is the most significant byte).
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    case (idx)
      3'd0:    mac_byte = mac[47:40];
      3'd1:    mac_byte = mac[39:32];
      3'd2:    mac_byte = mac[31:24];
      3'd3:    mac_byte = mac[23:16];
      3'd4:    mac_byte = mac[15:8];
      3'd5:    mac_byte = mac[7:0];
      default: mac_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/gmii_rx_da_match.sv
// Destination-address matcher: sticky unicast/broadcast match flags over DA bytes 0..5.
// Flags reflect all DA bytes the cycle after byte 5; no backpressure.
module gmii_rx_da_match
  import eth_rx_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC = 48'h00_0A_35_01_FE_C0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        valid,
  input  logic [10:0] idx,
  input  logic [7:0]  data,
  output logic        uni_ok,
  output logic        bc_ok
);

  logic in_da;
  assign in_da = valid && (idx < 11'd6);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uni_ok <= 1'b0;
      bc_ok  <= 1'b0;
    end else if (start) begin
      uni_ok <= 1'b1;
      bc_ok  <= 1'b1;
    end else if (in_da) begin
      if (data != mac_byte(LOCAL_MAC, idx[2:0])) uni_ok <= 1'b0;
      if (data != mac_byte(BCAST_MAC, idx[2:0])) bc_ok  <= 1'b0;
    end
  end

endmodule

// File: rtl/gmii_rx_frame_ctrl.sv
// GMII receive frame delineation: strips preamble/SFD, forwards DA..FCS with sof/eof, length/error status, counters.
// Latency 1 cycle from gmii_rxd to frm_data; no backpressure (GMII cannot be stalled).
module gmii_rx_frame_ctrl
  import eth_rx_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC = 48'h00_0A_35_01_FE_C0,
  parameter int          MIN_LEN   = 64,
  parameter int          MAX_LEN   = 1518,
  parameter bit          DA_CHECK  = 1'b1
) (
  input  logic        gmii_rx_clk,
  input  logic        rst,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rxdv,
  input  logic        gmii_rxerr,
  output logic [7:0]  frm_data,
  output logic        frm_valid,
  output logic        frm_sof,
  output logic        frm_eof,
  output logic [10:0] frm_len,
  output logic [2:0]  frm_err,
  output logic [15:0] cnt_good,
  output logic [15:0] cnt_bad
);

  localparam logic [10:0] MIN_L = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L = 11'(MAX_LEN);

  // Reset asserts immediately but releases on a clock edge.
  logic [1:0] rst_sync;
  logic       rst_int;
  always_ff @(posedge gmii_rx_clk or posedge rst) begin
    if (rst) rst_sync <= 2'b11;
    else     rst_sync <= {rst_sync[0], 1'b0};
  end
  assign rst_int = rst_sync[1];

  state_t      state, state_nxt;
  logic [3:0]  pre_cnt, pre_cnt_nxt;
  logic [10:0] byte_cnt, byte_cnt_nxt;
  logic        rx_bad, rx_bad_nxt;
  logic [7:0]  data_nxt;
  logic        valid_nxt, sof_nxt, eof_nxt;
  logic [10:0] len_nxt;
  logic [2:0]  err_nxt, end_err;
  logic        da_start, uni_ok, bc_ok;

  gmii_rx_da_match #(.LOCAL_MAC(LOCAL_MAC)) u_da_match (
    .clk    (gmii_rx_clk),
    .rst    (rst_int),
    .start  (da_start),
    .valid  (state == DATA && gmii_rxdv),
    .idx    (byte_cnt),
    .data   (gmii_rxd),
    .uni_ok (uni_ok),
    .bc_ok  (bc_ok)
  );

  // Status for a frame ending on rxdv deassertion.
  always_comb begin
    if (rx_bad)                                                  end_err = ERR_RX;
    else if (byte_cnt < MIN_L)                                   end_err = ERR_RUNT;
    else if (DA_CHECK && byte_cnt >= 11'd6 && !(uni_ok || bc_ok)) end_err = ERR_DA;
    else                                                         end_err = ERR_OK;
  end

  always_comb begin
    state_nxt    = state;
    pre_cnt_nxt  = pre_cnt;
    byte_cnt_nxt = byte_cnt;
    rx_bad_nxt   = rx_bad;
    data_nxt     = 8'h00;
    valid_nxt    = 1'b0;
    sof_nxt      = 1'b0;
    eof_nxt      = 1'b0;
    len_nxt      = frm_len;
    err_nxt      = frm_err;
    da_start     = 1'b0;
    case (state)
      IDLE: begin
        if (gmii_rxdv) begin
          if (gmii_rxd == PREAMBLE_BYTE) begin
            state_nxt   = PRE;
            pre_cnt_nxt = 4'd1;
          end else begin
            state_nxt = DROP;
          end
        end
      end
      PRE: begin
        if (!gmii_rxdv) begin
          state_nxt = IDLE;
        end else if (gmii_rxd == PREAMBLE_BYTE) begin
          if (pre_cnt >= 4'd7) state_nxt = DROP;
          else                 pre_cnt_nxt = pre_cnt + 4'd1;
        end else if (gmii_rxd == SFD_BYTE && pre_cnt != 4'd0 && pre_cnt <= 4'd7) begin
          state_nxt    = DATA;
          byte_cnt_nxt = 11'd0;
          rx_bad_nxt   = 1'b0;
          da_start     = 1'b1;
        end else begin
          state_nxt = DROP;
        end
      end
      DATA: begin
        if (gmii_rxdv) begin
          if (byte_cnt == MAX_L) begin
            // Byte beyond the maximum: truncate here and discard the rest.
            state_nxt = DROP;
            eof_nxt   = 1'b1;
            len_nxt   = MAX_L;
            err_nxt   = rx_bad ? ERR_RX : ERR_OVER;
          end else begin
            data_nxt     = gmii_rxd;
            valid_nxt    = 1'b1;
            sof_nxt      = (byte_cnt == 11'd0);
            byte_cnt_nxt = byte_cnt + 11'd1;
            rx_bad_nxt   = rx_bad | gmii_rxerr;
          end
        end else begin
          state_nxt = IDLE;
          eof_nxt   = 1'b1;
          len_nxt   = byte_cnt;
          err_nxt   = end_err;
        end
      end
      DROP: begin
        if (!gmii_rxdv) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge gmii_rx_clk or posedge rst_int) begin
    if (rst_int) begin
      state     <= IDLE;
      pre_cnt   <= 4'd0;
      byte_cnt  <= 11'd0;
      rx_bad    <= 1'b0;
      frm_data  <= 8'h00;
      frm_valid <= 1'b0;
      frm_sof   <= 1'b0;
      frm_eof   <= 1'b0;
      frm_len   <= 11'd0;
      frm_err   <= 3'd0;
      cnt_good  <= 16'd0;
      cnt_bad   <= 16'd0;
    end else begin
      state     <= state_nxt;
      pre_cnt   <= pre_cnt_nxt;
      byte_cnt  <= byte_cnt_nxt;
      rx_bad    <= rx_bad_nxt;
      frm_data  <= data_nxt;
      frm_valid <= valid_nxt;
      frm_sof   <= sof_nxt;
      frm_eof   <= eof_nxt;
      frm_len   <= len_nxt;
      frm_err   <= err_nxt;
      if (eof_nxt && err_nxt == ERR_OK && cnt_good != 16'hFFFF) cnt_good <= cnt_good + 16'd1;
      if (eof_nxt && err_nxt != ERR_OK && cnt_bad  != 16'hFFFF) cnt_bad  <= cnt_bad + 16'd1;
    end
  end

endmodule

// File: tb/tb_gmii_rx_frame_ctrl.sv
// Directed bench for gmii_rx_frame_ctrl; a second instance runs with the DA check disabled.
module tb_gmii_rx_frame_ctrl;

  localparam logic [47:0] MAC   = 48'h00_0A_35_01_FE_C0;
  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] OTHER = 48'h00_11_22_33_44_55;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rxd = 8'h00;
  logic        rxdv = 1'b0;
  logic        rxerr = 1'b0;

  logic [7:0]  frm_data, nc_data;
  logic        frm_valid, frm_sof, frm_eof, nc_valid, nc_sof, nc_eof;
  logic [10:0] frm_len, nc_len;
  logic [2:0]  frm_err, nc_err;
  logic [15:0] cnt_good, cnt_bad, nc_good, nc_bad;

  int tests = 0;
  int fails = 0;

  gmii_rx_frame_ctrl #(.DA_CHECK(1'b1)) dut (
    .gmii_rx_clk (clk), .rst (rst), .gmii_rxd (rxd), .gmii_rxdv (rxdv), .gmii_rxerr (rxerr),
    .frm_data (frm_data), .frm_valid (frm_valid), .frm_sof (frm_sof), .frm_eof (frm_eof),
    .frm_len (frm_len), .frm_err (frm_err), .cnt_good (cnt_good), .cnt_bad (cnt_bad)
  );

  gmii_rx_frame_ctrl #(.DA_CHECK(1'b0)) dut_nc (
    .gmii_rx_clk (clk), .rst (rst), .gmii_rxd (rxd), .gmii_rxdv (rxdv), .gmii_rxerr (rxerr),
    .frm_data (nc_data), .frm_valid (nc_valid), .frm_sof (nc_sof), .frm_eof (nc_eof),
    .frm_len (nc_len), .frm_err (nc_err), .cnt_good (nc_good), .cnt_bad (nc_bad)
  );

  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor; tests compare deltas against snapshots taken before stimulus.
  logic [7:0]  obs[$];
  int          n_sof = 0, n_eof = 0, last_sof_pos = -1, last_valid_cyc = 0, eof_cyc = 0;
  int          n_overlap = 0, nc_n_eof = 0;
  logic [10:0] last_len = 11'd0;
  logic [2:0]  last_err = 3'd0, nc_last_err = 3'd0;
  always @(negedge clk) begin
    if (frm_sof) begin n_sof++; last_sof_pos = obs.size(); end
    if (frm_valid) begin obs.push_back(frm_data); last_valid_cyc = cyc; end
    if (frm_eof) begin n_eof++; last_len = frm_len; last_err = frm_err; eof_cyc = cyc; end
    if (frm_eof && (frm_sof || frm_valid)) n_overlap++;
    if (nc_eof) begin nc_n_eof++; nc_last_err = nc_err; end
  end

  function automatic logic [7:0] fbyte(input logic [47:0] da, input int i);
    if (i < 6) return da[47-8*i -: 8];
    return 8'(i * 7 + 3);
  endfunction

  task automatic drive(input logic [7:0] d, input logic v, input logic e);
    @(negedge clk);
    rxd = d; rxdv = v; rxerr = e;
  endtask

  task automatic send_frame(input int pre_n, input logic [7:0] sfd, input logic [47:0] da,
                            input int len, input int err_at, input int gap);
    for (int i = 0; i < pre_n; i++) drive(8'h55, 1'b1, 1'b0);
    drive(sfd, 1'b1, 1'b0);
    for (int i = 0; i < len; i++) drive(fbyte(da, i), 1'b1, (i == err_at));
    for (int i = 0; i < gap; i++) drive(8'h00, 1'b0, 1'b0);
  endtask

  function automatic int byte_errs(input int base, input logic [47:0] da, input int n);
    int e = 0;
    for (int i = 0; i < n; i++) if (obs[base+i] !== fbyte(da, i)) e++;
    return e;
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++; if (frm_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", frm_valid); end
    tests++; if (frm_eof !== 1'b0) begin fails++; $display("FAIL reset_eof: got %b expected 0", frm_eof); end
    tests++; if (frm_len !== 11'd0) begin fails++; $display("FAIL reset_len: got %0d expected 0", frm_len); end
    tests++; if (cnt_good !== 16'd0 || cnt_bad !== 16'd0) begin
      fails++; $display("FAIL reset_cnt: got good=%0d bad=%0d expected 0/0", cnt_good, cnt_bad); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_good_frame();
    int bv = obs.size(), be = n_eof, bs = n_sof;
    send_frame(7, 8'hD5, MAC, 64, -1, 6);
    tests++; if (obs.size() - bv !== 64) begin fails++; $display("FAIL good_nbytes: got %0d expected 64", obs.size() - bv); end
    tests++; if (byte_errs(bv, MAC, 64) !== 0) begin fails++; $display("FAIL good_data: got %0d bad bytes expected 0", byte_errs(bv, MAC, 64)); end
    tests++; if (n_sof - bs !== 1 || last_sof_pos !== bv) begin
      fails++; $display("FAIL good_sof: got count=%0d pos=%0d expected 1 at %0d", n_sof - bs, last_sof_pos, bv); end
    tests++; if (n_eof - be !== 1 || eof_cyc - last_valid_cyc !== 1) begin
      fails++; $display("FAIL good_eof: got count=%0d gap=%0d expected 1/1", n_eof - be, eof_cyc - last_valid_cyc); end
    tests++; if (last_len !== 11'd64 || last_err !== 3'd0) begin
      fails++; $display("FAIL good_status: got len=%0d err=%0d expected 64/0", last_len, last_err); end
    tests++; if (cnt_good !== 16'd1 || cnt_bad !== 16'd0) begin
      fails++; $display("FAIL good_cnt: got %0d/%0d expected 1/0", cnt_good, cnt_bad); end
  endtask

  task automatic test_rxerr();
    int bv = obs.size();
    send_frame(7, 8'hD5, BCAST, 100, 20, 6);
    tests++; if (obs.size() - bv !== 100 || byte_errs(bv, BCAST, 100) !== 0) begin
      fails++; $display("FAIL rxerr_bytes: got %0d bytes expected 100 intact", obs.size() - bv); end
    tests++; if (last_len !== 11'd100 || last_err !== 3'd1) begin
      fails++; $display("FAIL rxerr_status: got len=%0d err=%0d expected 100/1", last_len, last_err); end
    tests++; if (cnt_bad !== 16'd1) begin fails++; $display("FAIL rxerr_cnt: got %0d expected 1", cnt_bad); end
  endtask

  task automatic test_runt();
    send_frame(7, 8'hD5, MAC, 40, -1, 6);
    tests++; if (last_len !== 11'd40 || last_err !== 3'd2) begin
      fails++; $display("FAIL runt40: got len=%0d err=%0d expected 40/2", last_len, last_err); end
    send_frame(7, 8'hD5, MAC, 0, -1, 6);
    tests++; if (last_len !== 11'd0 || last_err !== 3'd2 || cnt_bad !== 16'd3) begin
      fails++; $display("FAIL runt0: got len=%0d err=%0d bad=%0d expected 0/2/3", last_len, last_err, cnt_bad); end
  endtask

  task automatic test_oversize();
    int bv = obs.size(), be = n_eof;
    send_frame(7, 8'hD5, MAC, 1600, -1, 6);
    tests++; if (obs.size() - bv !== 1518 || byte_errs(bv, MAC, 1518) !== 0) begin
      fails++; $display("FAIL over_bytes: got %0d expected 1518 intact", obs.size() - bv); end
    tests++; if (n_eof - be !== 1 || last_len !== 11'd1518 || last_err !== 3'd3) begin
      fails++; $display("FAIL over_status: got eofs=%0d len=%0d err=%0d expected 1/1518/3", n_eof - be, last_len, last_err); end
    tests++; if (cnt_bad !== 16'd4) begin fails++; $display("FAIL over_cnt: got %0d expected 4", cnt_bad); end
  endtask

  task automatic test_da_mismatch();
    int bn = nc_n_eof;
    send_frame(7, 8'hD5, OTHER, 64, -1, 6);
    tests++; if (last_err !== 3'd4 || cnt_bad !== 16'd5) begin
      fails++; $display("FAIL da_check: got err=%0d bad=%0d expected 4/5", last_err, cnt_bad); end
    tests++; if (nc_n_eof - bn !== 1 || nc_last_err !== 3'd0) begin
      fails++; $display("FAIL da_nocheck: got eofs=%0d err=%0d expected 1/0", nc_n_eof - bn, nc_last_err); end
  endtask

  task automatic test_bad_preamble();
    int bv = obs.size(), be = n_eof;
    send_frame(2, 8'hAA, MAC, 70, -1, 4);
    send_frame(9, 8'hD5, MAC, 64, -1, 6);
    tests++; if (obs.size() - bv !== 0 || n_eof - be !== 0) begin
      fails++; $display("FAIL bad_pre_out: got bytes=%0d eofs=%0d expected 0/0", obs.size() - bv, n_eof - be); end
    tests++; if (cnt_good !== 16'd1 || cnt_bad !== 16'd5) begin
      fails++; $display("FAIL bad_pre_cnt: got %0d/%0d expected 1/5", cnt_good, cnt_bad); end
  endtask

  task automatic test_back_to_back();
    int bv = obs.size(), be = n_eof;
    send_frame(7, 8'hD5, MAC, 64, -1, 1);
    send_frame(1, 8'hD5, BCAST, 70, -1, 6);
    tests++; if (n_eof - be !== 2 || last_len !== 11'd70 || last_err !== 3'd0) begin
      fails++; $display("FAIL b2b_eof: got eofs=%0d len=%0d err=%0d expected 2/70/0", n_eof - be, last_len, last_err); end
    tests++; if (obs.size() - bv !== 134 || byte_errs(bv + 64, BCAST, 70) !== 0) begin
      fails++; $display("FAIL b2b_bytes: got %0d expected 134 intact", obs.size() - bv); end
    tests++; if (cnt_good !== 16'd3) begin fails++; $display("FAIL b2b_cnt: got %0d expected 3", cnt_good); end
  endtask

  task automatic test_reset_mid_frame();
    int be;
    for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) drive(fbyte(MAC, i), 1'b1, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    tests++; if (frm_valid !== 1'b0 || frm_data !== 8'h00) begin
      fails++; $display("FAIL rst_async_out: got valid=%b data=%h expected 0/00", frm_valid, frm_data); end
    tests++; if (cnt_good !== 16'd0 || cnt_bad !== 16'd0) begin
      fails++; $display("FAIL rst_async_cnt: got %0d/%0d expected 0/0", cnt_good, cnt_bad); end
    be = n_eof;
    rxdv = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    send_frame(7, 8'hD5, MAC, 64, -1, 6);
    tests++; if (n_eof - be !== 1 || last_len !== 11'd64 || last_err !== 3'd0) begin
      fails++; $display("FAIL rst_next_frame: got eofs=%0d len=%0d err=%0d expected 1/64/0", n_eof - be, last_len, last_err); end
    tests++; if (cnt_good !== 16'd1 || cnt_bad !== 16'd0) begin
      fails++; $display("FAIL rst_next_cnt: got %0d/%0d expected 1/0", cnt_good, cnt_bad); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_rxerr();
    test_runt();
    test_oversize();
    test_da_mismatch();
    test_bad_preamble();
    test_back_to_back();
    test_reset_mid_frame();
    tests++; if (n_overlap !== 0) begin fails++; $display("FAIL eof_overlap: got %0d expected 0", n_overlap); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
